// File: rtl/ultrasonic_ranger_mc_pkg.sv
// Shared definitions for the multi-channel ultrasonic ranger: FSM state codes and alarm level codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ultrasonic_ranger_mc_pkg;

    // Scan sequencer states; one shared FSM serves every channel in turn.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_GAP       = 3'd4
    } ranger_state_t;

    // Alarm level codes as seen on alarm_level_o and by the buzzer pattern generator.
    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_WARN = 2'd1;
    localparam logic [1:0] LVL_NEAR = 2'd2;

    // Width of the channel index published with each result.
    localparam int CH_W = 3;

endpackage

// File: rtl/ultrasonic_ranger_mc_beep_gen.sv
// Buzzer pattern generator: off at level 0, square wave at level 1, solid on at level 2.
// Latency: buzzer_o follows level_i by one clock; level-1 pattern starts with an on half.
// Backpressure: none; free-running from level_i.
// Ports: clk_i, rst_i (async active-high), level_i (alarm code), buzzer_o (drive).
module ultrasonic_ranger_mc_beep_gen
    import ultrasonic_ranger_mc_pkg::*;
#(
    parameter int BEEP_HALF_CYC = 1500000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] level_i,
    output logic       buzzer_o
);

    localparam int            BW      = (BEEP_HALF_CYC > 2) ? $clog2(BEEP_HALF_CYC) : 1;
    localparam logic [BW-1:0] HALF_M1 = BW'(BEEP_HALF_CYC - 1);

    logic [BW-1:0] cnt_q, cnt_d;
    logic          buz_q, buz_d;
    logic [1:0]    lvl_q;

    always_comb begin
        cnt_d = cnt_q;
        buz_d = buz_q;
        case (level_i)
            LVL_WARN: begin
                // Restart the phase whenever level 1 is freshly entered so the
                // first beep is always a full on-half.
                if (lvl_q != LVL_WARN) begin
                    cnt_d = '0;
                    buz_d = 1'b1;
                end else if (cnt_q >= HALF_M1) begin
                    cnt_d = '0;
                    buz_d = ~buz_q;
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            LVL_NEAR: begin
                cnt_d = '0;
                buz_d = 1'b1;
            end
            default: begin
                cnt_d = '0;
                buz_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            buz_q <= 1'b0;
            lvl_q <= LVL_NONE;
        end else begin
            cnt_q <= cnt_d;
            buz_q <= buz_d;
            lvl_q <= level_i;
        end
    end

    assign buzzer_o = buz_q;

endmodule

// File: rtl/ultrasonic_ranger_mc.sv
// Multi-channel ultrasonic ranger: fires sensors round-robin, times echoes with timeout, drives proximity alarm/buzzer.
// Latency: raw echo fall -> meas_valid_o in 4 clocks; alarm_level_o one clock after the strobe; buzzer one more.
// Backpressure: none; results are strobed and held, en_i=0 stops the scan only once the current channel completes.
// Ports: clk_i, rst_i (async active-high), en_i, echo_i[N_CH] raw; trigger_o[N_CH]; meas_valid_o/meas_ch_o/meas_cyc_o/
//        meas_timeout_o result; alarm_level_o (0 none, 1 warn, 2 near); buzzer_o.
module ultrasonic_ranger_mc
    import ultrasonic_ranger_mc_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int CNT_W         = 20,
    parameter int TRIG_CYC      = 120,
    parameter int PERIOD_CYC    = 720000,
    parameter int TIMEOUT_CYC   = 360000,
    parameter int NEAR_CYC      = 17400,
    parameter int WARN_CYC      = 69600,
    parameter int BEEP_HALF_CYC = 1500000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [N_CH-1:0]   echo_i,
    output logic [N_CH-1:0]   trigger_o,
    output logic              meas_valid_o,
    output logic [CH_W-1:0]   meas_ch_o,
    output logic [CNT_W-1:0]  meas_cyc_o,
    output logic              meas_timeout_o,
    output logic [1:0]        alarm_level_o,
    output logic              buzzer_o
);

    localparam logic [CNT_W-1:0] TRIG_M1 = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] PER_M1  = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] NEAR_C  = CNT_W'(NEAR_CYC);
    localparam logic [CNT_W-1:0] WARN_C  = CNT_W'(WARN_CYC);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);

    ranger_state_t    state_q, state_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;      // phase counter: trigger width, rise wait, echo length
    logic [CNT_W-1:0] per_q, per_d;      // cycles since the current trigger rise
    logic             to_q, to_d;        // current result is a timeout
    logic             gap_new_q;         // first cycle in GAP: publish the result
    logic [N_CH-1:0]  sync1_q, sync2_q;
    logic [N_CH-1:0]  trig_q, trig_d;
    logic             echo_s;

    logic             meas_valid_q;
    logic [CH_W-1:0]  meas_ch_q;
    logic [CNT_W-1:0] meas_cyc_q;
    logic             meas_to_q;

    logic [CNT_W-1:0] range_q [N_CH];
    logic [CNT_W-1:0] min_rng;
    logic [1:0]       alarm_q, alarm_d;

    // Only the channel currently being served is looked at.
    always_comb begin
        echo_s = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ptr_q == CH_W'(i)) echo_s = sync2_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        // Period counter saturates so an over-long measurement cannot wrap it.
        per_d   = (per_q >= PER_M1) ? per_q : per_q + CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                per_d = per_q;
                if (en_i) begin
                    state_d = ST_TRIG;
                    cnt_d   = '0;
                    per_d   = '0;
                    to_d    = 1'b0;
                end
            end
            ST_TRIG: begin
                if (cnt_q >= TRIG_M1) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_RISE: begin
                // The rise-detect cycle is itself an echo-high cycle, so it is counted.
                if (echo_s) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q >= TMO_M1) begin
                    state_d = ST_GAP;
                    cnt_d   = TMO;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MEASURE: begin
                if (!echo_s) begin
                    state_d = ST_GAP;
                end else if (cnt_q >= TMO_M1) begin
                    state_d = ST_GAP;
                    cnt_d   = TMO;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                // cnt_q/to_q hold the result here until the next trigger.
                if (per_q >= PER_M1) begin
                    ptr_d = (ptr_q >= LAST_CH) ? '0 : ptr_q + CH_W'(1);
                    if (en_i) begin
                        state_d = ST_TRIG;
                        cnt_d   = '0;
                        per_d   = '0;
                        to_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Trigger is registered from the next state so it is glitch-free and
    // coincides exactly with the TRIG state.
    always_comb begin
        trig_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            trig_d[i] = (state_d == ST_TRIG) && (ptr_d == CH_W'(i));
        end
    end

    always_comb begin
        min_rng = range_q[0];
        for (int i = 1; i < N_CH; i++) begin
            if (range_q[i] < min_rng) min_rng = range_q[i];
        end
        if (min_rng < NEAR_C)      alarm_d = LVL_NEAR;
        else if (min_rng < WARN_C) alarm_d = LVL_WARN;
        else                       alarm_d = LVL_NONE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            per_q        <= '0;
            to_q         <= 1'b0;
            gap_new_q    <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            trig_q       <= '0;
            meas_valid_q <= 1'b0;
            meas_ch_q    <= '0;
            meas_cyc_q   <= '0;
            meas_to_q    <= 1'b0;
            alarm_q      <= LVL_NONE;
            for (int i = 0; i < N_CH; i++) range_q[i] <= TMO;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            per_q        <= per_d;
            to_q         <= to_d;
            gap_new_q    <= (state_d == ST_GAP) && (state_q != ST_GAP);
            sync1_q      <= echo_i;
            sync2_q      <= sync1_q;
            trig_q       <= trig_d;
            meas_valid_q <= gap_new_q;
            alarm_q      <= alarm_d;
            if (gap_new_q) begin
                meas_ch_q  <= ptr_q;
                meas_cyc_q <= cnt_q;
                meas_to_q  <= to_q;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (gap_new_q && (ptr_q == CH_W'(i))) range_q[i] <= cnt_q;
            end
        end
    end

    ultrasonic_ranger_mc_beep_gen #(
        .BEEP_HALF_CYC (BEEP_HALF_CYC)
    ) u_beep (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .level_i  (alarm_q),
        .buzzer_o (buzzer_o)
    );

    assign trigger_o      = trig_q;
    assign meas_valid_o   = meas_valid_q;
    assign meas_ch_o      = meas_ch_q;
    assign meas_cyc_o     = meas_cyc_q;
    assign meas_timeout_o = meas_to_q;
    assign alarm_level_o  = alarm_q;

endmodule
